// File: rtl/pong_match_if.sv
// Match controller <-> ball engine / score counter / display signal bundle.
// master = match controller side, slave = the surrounding datapath.
interface pong_match_if;
  logic       start, pause, miss_left, miss_right;
  logic [3:0] p1_unit, p1_tens, p2_unit, p2_tens;
  logic       score1, score2, score_clear;
  logic       ball_reset, ball_enable, serve_dir, game_over;
  logic [1:0] winner;

  modport master (
    input  start, pause, miss_left, miss_right,
    input  p1_unit, p1_tens, p2_unit, p2_tens,
    output score1, score2, score_clear,
    output ball_reset, ball_enable, serve_dir, game_over, winner
  );

  modport slave (
    output start, pause, miss_left, miss_right,
    output p1_unit, p1_tens, p2_unit, p2_tens,
    input  score1, score2, score_clear,
    input  ball_reset, ball_enable, serve_dir, game_over, winner
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: IDLE -> SERVE -> PLAY -> POINT -> CHECK -> SERVE/OVER.
// Define PONG_PAUSE_EN to let the pause switch freeze SERVE and PLAY.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 100000000,
  parameter int CNT_W       = $clog2(SERVE_DELAY+1)
) (
  input  logic         clk,
  input  logic         reset,
  pong_match_if.master bus
);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, CHECK, OVER} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY-1);
  localparam logic [6:0]       WIN      = 7'(WIN_SCORE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_rise, frz;
  logic             score1_q, score1_d, score2_q, score2_d, clear_q, clear_d;
  logic             dir_q, dir_d, ball_reset_q, ball_enable_q, game_over_q;
  logic [1:0]       win_q, win_d;
  logic [6:0]       p1_score, p2_score;

  assign start_rise = bus.start & ~start_q;
  assign p1_score   = 7'(bus.p1_tens) * 7'd10 + 7'(bus.p1_unit);
  assign p2_score   = 7'(bus.p2_tens) * 7'd10 + 7'(bus.p2_unit);

`ifdef PONG_PAUSE_EN
  assign frz = bus.pause & ((state_q == SERVE) | (state_q == PLAY));
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
  assign frz          = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score1_d = 1'b0;
    score2_d = 1'b0;
    clear_d  = 1'b0;
    dir_d    = dir_q;
    win_d    = win_q;
    if (!frz) begin
      case (state_q)
        IDLE, OVER: if (start_rise) begin
          clear_d = 1'b1;
          dir_d   = 1'b0;
          win_d   = 2'b00;
          cnt_d   = '0;
          state_d = SERVE;
        end
        SERVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PLAY: begin
          // Serve goes toward whoever just conceded.
          case ({bus.miss_left, bus.miss_right})
            2'b10: begin score2_d = 1'b1; dir_d = 1'b0; state_d = POINT; end
            2'b01: begin score1_d = 1'b1; dir_d = 1'b1; state_d = POINT; end
            2'b11: begin cnt_d = '0; state_d = SERVE; end
            default: ;
          endcase
        end
        POINT: state_d = CHECK;
        CHECK: begin
          if (p1_score >= WIN) begin
            win_d   = 2'b01;
            state_d = OVER;
          end else if (p2_score >= WIN) begin
            win_d   = 2'b10;
            state_d = OVER;
          end else begin
            cnt_d   = '0;
            state_d = SERVE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      score1_q      <= 1'b0;
      score2_q      <= 1'b0;
      clear_q       <= 1'b0;
      dir_q         <= 1'b0;
      win_q         <= 2'b00;
      ball_reset_q  <= 1'b1;
      ball_enable_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_q       <= bus.start;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      clear_q       <= clear_d;
      dir_q         <= dir_d;
      win_q         <= win_d;
      ball_reset_q  <= (state_d != PLAY);
      ball_enable_q <= (state_d == PLAY) & ~frz;
      game_over_q   <= (state_d == OVER);
    end
  end

  assign bus.score1      = score1_q;
  assign bus.score2      = score2_q;
  assign bus.score_clear = clear_q;
  assign bus.ball_reset  = ball_reset_q;
  assign bus.ball_enable = ball_enable_q;
  assign bus.serve_dir   = dir_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = win_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: per-cycle vector table through a scoreboard queue,
// with a BCD score counter model closing the score feedback loop.
module tb_pong_match_ctrl;
  localparam int SD = 4;
  localparam int WS = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_match_if bus();
  pong_match_ctrl #(.WIN_SCORE(WS), .SERVE_DELAY(SD)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Score counter model, sharing the controller's reset.
  logic [3:0] m1u, m1t, m2u, m2t;
  always @(posedge clk) begin
    if (reset || bus.score_clear) begin
      m1u <= 0; m1t <= 0; m2u <= 0; m2t <= 0;
    end else begin
      if (bus.score1) begin
        if (m1u == 9) begin m1u <= 0; m1t <= (m1t == 9) ? 4'd0 : m1t + 4'd1; end
        else m1u <= m1u + 4'd1;
      end
      if (bus.score2) begin
        if (m2u == 9) begin m2u <= 0; m2t <= (m2t == 9) ? 4'd0 : m2t + 4'd1; end
        else m2u <= m2u + 4'd1;
      end
    end
  end
  assign bus.p1_unit = m1u;
  assign bus.p1_tens = m1t;
  assign bus.p2_unit = m2u;
  assign bus.p2_tens = m2t;

  typedef struct {
    bit         mark;
    bit         rst, st, ml, mr, pa;
    logic [8:0] exp;
    int         p1e, p2e;
  } vec_t;

  vec_t       vq[$];
  logic [8:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  // Expected output word: {score1, score2, score_clear, ball_reset, ball_enable, serve_dir, game_over, winner}
  function automatic logic [8:0] o(bit s1, bit s2, bit clr, bit br, bit be, bit dir, bit go, bit [1:0] w);
    return {s1, s2, clr, br, be, dir, go, w};
  endfunction

  function automatic void add(bit rst, bit st, bit ml, bit mr, bit pa, logic [8:0] e);
    vec_t v;
    v.mark = 0; v.rst = rst; v.st = st; v.ml = ml; v.mr = mr; v.pa = pa;
    v.exp = e; v.p1e = 0; v.p2e = 0;
    vq.push_back(v);
  endfunction

  function automatic void sc(int p1, int p2);
    vec_t v;
    v.mark = 1; v.rst = 0; v.st = 0; v.ml = 0; v.mr = 0; v.pa = 0;
    v.exp = '0; v.p1e = p1; v.p2e = p2;
    vq.push_back(v);
  endfunction

  // From SERVE with counter 0: three more SERVE cycles, then PLAY.
  function automatic void to_play(bit st, bit ml, bit mr, bit dir);
    for (int k = 0; k < SD - 1; k++) add(0, st, ml, mr, 0, o(0,0,0,1,0,dir,0,2'b00));
    add(0, st, ml, mr, 0, o(0,0,0,0,1,dir,0,2'b00));
  endfunction

  // Non-winning point for player 2, from PLAY back to PLAY.
  function automatic void p2_point();
    add(0, 0, 1, 0, 0, o(0,1,0,1,0,0,0,2'b00));
    add(0, 0, 0, 0, 0, o(0,0,0,1,0,0,0,2'b00));
    add(0, 0, 0, 0, 0, o(0,0,0,1,0,0,0,2'b00));
    to_play(0, 0, 0, 0);
  endfunction

  initial begin
    logic [8:0] got, e;
    int p1, p2;

    // Reset state, then start; start stays high through the serve (no retrigger).
    add(1, 0, 0, 0, 0, o(0,0,0,1,0,0,0,2'b00));
    add(0, 0, 0, 0, 0, o(0,0,0,1,0,0,0,2'b00));
    add(0, 1, 0, 0, 0, o(0,0,1,1,0,0,0,2'b00));
    to_play(1, 0, 0, 0);
    // miss_right held through POINT, CHECK and the whole serve: one award only.
    add(0, 0, 0, 1, 0, o(1,0,0,1,0,1,0,2'b00));
    add(0, 0, 0, 1, 0, o(0,0,0,1,0,1,0,2'b00));
    sc(1, 0);
    add(0, 0, 0, 1, 0, o(0,0,0,1,0,1,0,2'b00));
    to_play(0, 0, 1, 1);
    add(0, 0, 0, 0, 0, o(0,0,0,0,1,1,0,2'b00));
    sc(1, 0);
    // Simultaneous misses: no award, re-serve, direction kept.
    add(0, 0, 1, 1, 0, o(0,0,0,1,0,1,0,2'b00));
    to_play(0, 0, 0, 1);
    sc(1, 0);
    p2_point();
    p2_point();
    sc(1, 2);
    // Reset mid-play: back to IDLE, no clear pulse, needs a fresh start press.
    add(1, 0, 0, 0, 0, o(0,0,0,1,0,0,0,2'b00));
    sc(0, 0);
    add(0, 0, 0, 0, 0, o(0,0,0,1,0,0,0,2'b00));
    add(0, 0, 0, 1, 0, o(0,0,0,1,0,0,0,2'b00));
    add(0, 1, 0, 0, 0, o(0,0,1,1,0,0,0,2'b00));
    to_play(0, 0, 0, 0);
    p2_point();
    p2_point();
    // Winning point for player 2.
    add(0, 0, 1, 0, 0, o(0,1,0,1,0,0,0,2'b00));
    add(0, 0, 0, 0, 0, o(0,0,0,1,0,0,0,2'b00));
    add(0, 0, 0, 0, 0, o(0,0,0,1,0,0,1,2'b10));
    sc(0, 3);
    add(0, 0, 1, 0, 0, o(0,0,0,1,0,0,1,2'b10));
    add(0, 0, 0, 1, 0, o(0,0,0,1,0,0,1,2'b10));
    add(0, 0, 1, 1, 0, o(0,0,0,1,0,0,1,2'b10));
    sc(0, 3);
    add(0, 1, 0, 0, 0, o(0,0,1,1,0,0,0,2'b00));
    add(0, 1, 0, 0, 0, o(0,0,0,1,0,0,0,2'b00));
    sc(0, 0);
    add(0, 0, 0, 0, 0, o(0,0,0,1,0,0,0,2'b00));
`ifdef PONG_PAUSE_EN
    // Serve counter at 2: pause 20 cycles (with misses), then two SERVE cycles remain.
    for (int k = 0; k < 20; k++) add(0, 0, k[0], k[1], 1, o(0,0,0,1,0,0,0,2'b00));
    add(0, 0, 0, 0, 0, o(0,0,0,1,0,0,0,2'b00));
    add(0, 0, 0, 0, 0, o(0,0,0,0,1,0,0,2'b00));
    for (int k = 0; k < 5; k++) add(0, 0, 1, 0, 1, o(0,0,0,0,0,0,0,2'b00));
    add(0, 0, 0, 0, 0, o(0,0,0,0,1,0,0,2'b00));
    sc(0, 0);
    add(0, 0, 0, 1, 0, o(1,0,0,1,0,1,0,2'b00));
    add(0, 0, 0, 0, 0, o(0,0,0,1,0,1,0,2'b00));
    sc(1, 0);
`else
    // Pause is inert: serve completes and a miss is awarded regardless.
    add(0, 0, 0, 0, 1, o(0,0,0,1,0,0,0,2'b00));
    add(0, 0, 0, 0, 1, o(0,0,0,0,1,0,0,2'b00));
    add(0, 0, 1, 0, 1, o(0,1,0,1,0,0,0,2'b00));
    add(0, 0, 0, 0, 1, o(0,0,0,1,0,0,0,2'b00));
    sc(0, 1);
`endif

    reset = 1'b1;
    bus.start = 0; bus.pause = 0; bus.miss_left = 0; bus.miss_right = 0;

    foreach (vq[i]) begin
      if (vq[i].mark) begin
        p1 = int'(m1t) * 10 + int'(m1u);
        p2 = int'(m2t) * 10 + int'(m2u);
        checks++;
        if (p1 != vq[i].p1e || p2 != vq[i].p2e) begin
          errors++;
          $display("FAIL vec%0d scores got=%0d-%0d exp=%0d-%0d", i, p1, p2, vq[i].p1e, vq[i].p2e);
        end
      end else begin
        @(negedge clk);
        reset          = vq[i].rst;
        bus.start      = vq[i].st;
        bus.miss_left  = vq[i].ml;
        bus.miss_right = vq[i].mr;
        bus.pause      = vq[i].pa;
        exp_q.push_back(vq[i].exp);
        @(posedge clk);
        #1;
        got = {bus.score1, bus.score2, bus.score_clear, bus.ball_reset, bus.ball_enable,
               bus.serve_dir, bus.game_over, bus.winner};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL vec%0d outputs {s1,s2,clr,br,be,dir,go,win} got=%b exp=%b", i, got, e);
        end
        checks++;
        if ((bus.score1 && bus.score2) || (bus.score_clear && (bus.score1 || bus.score2))) begin
          errors++;
          $display("FAIL vec%0d pulse_overlap got s1=%b s2=%b clr=%b exp no overlap",
                   i, bus.score1, bus.score2, bus.score_clear);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
